if_id_skid_buf: RTL and testbench



---
 rtl/if_id_skid_buf.sv | 130 +++++++++++++
 tb/tb_if_id_skid_buf.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_buf.sv
// rtl/if_id_skid_buf.sv - IF/ID pipeline register with valid/ready handshake and two-entry skid buffer
// Optional feature: IF_ID_NOP_FILL_EN forces pc_o=0 / inst_o=NOP_INST whenever out_valid_o is low.
module if_id_skid_buf #(
    parameter int unsigned          PC_W     = 32,
    parameter int unsigned          INST_W   = 32,
    parameter logic [INST_W-1:0]    NOP_INST = 32'h00000013
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [INST_W-1:0] inst_o,
    output logic [1:0]        count_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [PC_W-1:0]   main_pc_q, skid_pc_q;
    logic [INST_W-1:0] main_inst_q, skid_inst_q;

    logic accept;
    logic consume;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid_in;

    // Ready depends only on registered state, so decode's ready never reaches fetch combinationally.
    assign in_ready_o  = (state_q != ST_FULL);
    assign out_valid_o = (state_q != ST_EMPTY);
    assign accept      = in_valid_i & in_ready_o & ~flush_i;
    assign consume     = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        load_main_in = 1'b1;
                        state_d      = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        load_skid_in = 1'b1;
                        state_d      = ST_FULL;
                    end else if (consume) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (consume) begin
                        load_main_skid = 1'b1;
                        state_d        = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Payload only moves when its entry is written; flush leaves it in place.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            main_pc_q   <= '0;
            main_inst_q <= NOP_INST;
        end else if (load_main_in) begin
            main_pc_q   <= pc_i;
            main_inst_q <= inst_i;
        end else if (load_main_skid) begin
            main_pc_q   <= skid_pc_q;
            main_inst_q <= skid_inst_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            skid_pc_q   <= '0;
            skid_inst_q <= NOP_INST;
        end else if (load_skid_in) begin
            skid_pc_q   <= pc_i;
            skid_inst_q <= inst_i;
        end
    end

    always_comb begin
        count_o = 2'd0;
        case (state_q)
            ST_ONE:  count_o = 2'd1;
            ST_FULL: count_o = 2'd2;
            default: count_o = 2'd0;
        endcase
    end

`ifdef IF_ID_NOP_FILL_EN
    assign pc_o   = out_valid_o ? main_pc_q   : '0;
    assign inst_o = out_valid_o ? main_inst_q : NOP_INST;
`else
    assign pc_o   = main_pc_q;
    assign inst_o = main_inst_q;
`endif

endmodule

// File: tb/tb_if_id_skid_buf.sv
// tb/tb_if_id_skid_buf.sv - directed self-checking bench for if_id_skid_buf
module tb_if_id_skid_buf;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic [1:0]  count_o;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] NOP = 32'h00000013;

    if_id_skid_buf dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .pc_i        (pc_i),
        .inst_i      (inst_i),
        .flush_i     (flush_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .pc_o        (pc_o),
        .inst_o      (inst_o),
        .count_o     (count_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] pc);
        in_valid_i = v;
        pc_i       = pc;
        inst_i     = inst_of(pc);
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [1:0] cnt,
                              input logic rdy, input logic [31:0] pc);
        check({tag, ".valid"}, 64'(out_valid_o), 64'(v));
        check({tag, ".count"}, 64'(count_o), 64'(cnt));
        check({tag, ".ready"}, 64'(in_ready_o), 64'(rdy));
        check({tag, ".pc"}, 64'(pc_o), 64'(pc));
        check({tag, ".inst"}, 64'(inst_o), 64'(v ? inst_of(pc) : inst_o));
    endtask

    initial begin
        rst_n_i     = 1'b0;
        flush_i     = 1'b0;
        out_ready_i = 1'b0;
        offer(1'b0, 32'h0);
        tick();
        check("rst.valid", 64'(out_valid_o), 64'd0);
        check("rst.ready", 64'(in_ready_o), 64'd1);
        check("rst.count", 64'(count_o), 64'd0);
        check("rst.pc", 64'(pc_o), 64'd0);
        check("rst.inst", 64'(inst_o), 64'(NOP));
        rst_n_i = 1'b1;
        tick();
        check("post_rst.count", 64'(count_o), 64'd0);

        // Streaming at full throughput
        out_ready_i = 1'b1;
        offer(1'b1, 32'h100); tick(); expect_out("s100", 1'b1, 2'd1, 1'b1, 32'h100);
        offer(1'b1, 32'h104); tick(); expect_out("s104", 1'b1, 2'd1, 1'b1, 32'h104);
        offer(1'b1, 32'h108); tick(); expect_out("s108", 1'b1, 2'd1, 1'b1, 32'h108);
        offer(1'b0, 32'h0);   tick();
        check("drain.valid", 64'(out_valid_o), 64'd0);
        check("drain.count", 64'(count_o), 64'd0);
`ifdef IF_ID_NOP_FILL_EN
        check("drain.pc", 64'(pc_o), 64'd0);
        check("drain.inst", 64'(inst_o), 64'(NOP));
`else
        check("drain.pc", 64'(pc_o), 64'h108);
        check("drain.inst", 64'(inst_o), 64'(inst_of(32'h108)));
`endif

        // Stall: second word goes to skid, third is refused
        out_ready_i = 1'b0;
        offer(1'b1, 32'h200); tick(); expect_out("st200", 1'b1, 2'd1, 1'b1, 32'h200);
        offer(1'b1, 32'h204); tick(); expect_out("st204", 1'b1, 2'd2, 1'b0, 32'h200);
        offer(1'b1, 32'h208); tick(); expect_out("st208", 1'b1, 2'd2, 1'b0, 32'h200);
        out_ready_i = 1'b1;
        tick(); expect_out("rel204", 1'b1, 2'd1, 1'b1, 32'h204);
        tick(); expect_out("rel208", 1'b1, 2'd1, 1'b1, 32'h208);
        offer(1'b0, 32'h0);
        tick();
        check("rel.count", 64'(count_o), 64'd0);

        // Flush while FULL drops held and incoming words
        out_ready_i = 1'b0;
        offer(1'b1, 32'h280); tick();
        offer(1'b1, 32'h284); tick();
        check("ff.count_pre", 64'(count_o), 64'd2);
        flush_i = 1'b1;
        offer(1'b1, 32'h300); tick();
        check("ff.valid", 64'(out_valid_o), 64'd0);
        check("ff.count", 64'(count_o), 64'd0);
        check("ff.ready", 64'(in_ready_o), 64'd1);
`ifdef IF_ID_NOP_FILL_EN
        check("ff.pc", 64'(pc_o), 64'd0);
        check("ff.inst", 64'(inst_o), 64'(NOP));
`else
        check("ff.pc", 64'(pc_o), 64'h280);
        check("ff.inst", 64'(inst_o), 64'(inst_of(32'h280)));
`endif
        flush_i = 1'b0;
        offer(1'b0, 32'h0);
        out_ready_i = 1'b1;
        tick();
        check("ff.after_valid", 64'(out_valid_o), 64'd0);

        // Flush coinciding with consume in ONE
        out_ready_i = 1'b0;
        offer(1'b1, 32'h400); tick();
        offer(1'b0, 32'h0);
        out_ready_i = 1'b1;
        flush_i     = 1'b1;
        #1;
        check("fc.consume_valid", 64'(out_valid_o), 64'd1);
        check("fc.consume_pc", 64'(pc_o), 64'h400);
        tick();
        flush_i = 1'b0;
        check("fc.valid", 64'(out_valid_o), 64'd0);
        check("fc.count", 64'(count_o), 64'd0);
        tick();
        check("fc.no_redeliver", 64'(out_valid_o), 64'd0);

        // Asynchronous reset while FULL
        out_ready_i = 1'b0;
        offer(1'b1, 32'h500); tick();
        offer(1'b1, 32'h504); tick();
        check("ar.count_pre", 64'(count_o), 64'd2);
        offer(1'b0, 32'h0);
        #2 rst_n_i = 1'b0;
        #1;
        check("ar.valid", 64'(out_valid_o), 64'd0);
        check("ar.count", 64'(count_o), 64'd0);
        check("ar.ready", 64'(in_ready_o), 64'd1);
        check("ar.pc", 64'(pc_o), 64'd0);
        check("ar.inst", 64'(inst_o), 64'(NOP));
        #1 rst_n_i = 1'b1;
        tick();
        check("ar.after_count", 64'(count_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
